llc_mem_bridge: RTL and testbench

Memory-side counterpart of the LLC's `llc_mem_req` / `llc_mem_rsp` channel: it accepts line-granular read and write requests issued by the LLC core and returns full lines for reads. It serialises each line into word-wide commands on a simple pipelined memory bus and assembles read-data beats back into a line. It sits between the LLC core and the memory controller / NoC memory tile adapter, one instance per LLC slice.

---
 rtl/llc_mem_bridge_pkg.sv | 35 +++
 rtl/llc_mem_bridge_if.sv | 38 +++
 rtl/llc_mem_bridge_line_assembler.sv | 56 +++++
 rtl/llc_mem_bridge.sv | 145 ++++++++++++++
 tb/tb_llc_mem_bridge.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/llc_mem_bridge_pkg.sv
// Shared LLC memory-channel types and cache geometry constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package llc_mem_bridge_pkg;

   localparam int WORDS_PER_LINE = 4;
   localparam int BITS_PER_WORD  = 32;
   localparam int ADDR_BITS      = 32;
   localparam int HPROT_WIDTH    = 2;
   localparam int HSIZE_WIDTH    = 3;

   localparam int WORD_OFFSET    = $clog2(WORDS_PER_LINE);
   localparam int BYTE_OFFSET    = $clog2(BITS_PER_WORD / 8);
   localparam int LINE_ADDR_BITS = ADDR_BITS - WORD_OFFSET - BYTE_OFFSET;
   localparam int LINE_BITS      = WORDS_PER_LINE * BITS_PER_WORD;

   typedef logic [LINE_BITS-1:0]      line_t;
   typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
   typedef logic [HPROT_WIDTH-1:0]    hprot_t;
   typedef logic [HSIZE_WIDTH-1:0]    hsize_t;
   typedef logic [BITS_PER_WORD-1:0]  word_t;

   typedef struct packed {
      logic       hwrite;
      hsize_t     hsize;
      hprot_t     hprot;
      line_addr_t addr;
      line_t      line;
   } llc_mem_req_t;

   typedef struct packed {
      line_t line;
   } llc_mem_rsp_t;

endpackage

// File: rtl/llc_mem_bridge_if.sv
// LLC request/response channel plus word-wide memory command/read-data bus.
// Latency: n/a (wires only).
// Backpressure: req and rsp are valid/ready; mem_cmd is valid/ready; mem_rdata has none.
// Ports: slave = bridge side (takes LLC requests, drives memory commands),
//        master = environment side (LLC core + memory controller).
interface llc_mem_bridge_if;
   import llc_mem_bridge_pkg::*;

   logic          llc_mem_req_valid;
   logic          llc_mem_req_ready;
   llc_mem_req_t  llc_mem_req;
   logic          llc_mem_rsp_valid;
   logic          llc_mem_rsp_ready;
   llc_mem_rsp_t  llc_mem_rsp;
   logic          mem_cmd_valid;
   logic          mem_cmd_ready;
   logic          mem_cmd_write;
   logic [ADDR_BITS-1:0] mem_cmd_addr;
   hprot_t        mem_cmd_hprot;
   word_t         mem_cmd_wdata;
   logic          mem_rdata_valid;
   word_t         mem_rdata;

   modport slave (
      input  llc_mem_req_valid, llc_mem_req, llc_mem_rsp_ready,
             mem_cmd_ready, mem_rdata_valid, mem_rdata,
      output llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp,
             mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_hprot, mem_cmd_wdata
   );

   modport master (
      output llc_mem_req_valid, llc_mem_req, llc_mem_rsp_ready,
             mem_cmd_ready, mem_rdata_valid, mem_rdata,
      input  llc_mem_req_ready, llc_mem_rsp_valid, llc_mem_rsp,
             mem_cmd_valid, mem_cmd_write, mem_cmd_addr, mem_cmd_hprot, mem_cmd_wdata
   );

endinterface

// File: rtl/llc_mem_bridge_line_assembler.sv
// Collects word-wide read beats into a cache line, in arrival order.
// Latency: beat written into the line on the clock edge that samples it.
// Backpressure: none; caller only presents beats it has already qualified.
// Ports: clr_i restarts the beat count, beat_vld_i/beat_dat_i write word beat_cnt_o,
//        line_o is the assembled line, full_o is high once every word has landed.
module llc_line_assembler #(
   parameter int WORDS_PER_LINE = 4,
   parameter int BITS_PER_WORD  = 32
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    clr_i,
   input  logic                                    beat_vld_i,
   input  logic [BITS_PER_WORD-1:0]                beat_dat_i,
   output logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] line_o,
   output logic [$clog2(WORDS_PER_LINE):0]         beat_cnt_o,
   output logic                                    full_o
);
   import llc_mem_bridge_pkg::*;

   localparam int WO = $clog2(WORDS_PER_LINE);
   localparam int CW = WO + 1;
   localparam int LB = WORDS_PER_LINE * BITS_PER_WORD;

   logic [LB-1:0] line_q, line_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WO-1:0] idx;

   assign idx = cnt_q[WO-1:0];

   always_comb begin
      line_d = line_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (beat_vld_i) begin
         line_d[idx*BITS_PER_WORD +: BITS_PER_WORD] = beat_dat_i;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_q <= '0;
         cnt_q  <= '0;
      end else begin
         line_q <= line_d;
         cnt_q  <= cnt_d;
      end
   end

   assign line_o     = line_q;
   assign beat_cnt_o = cnt_q;
   assign full_o     = (cnt_q == CW'(WORDS_PER_LINE));

endmodule

// File: rtl/llc_mem_bridge.sv
// Bridges line-granular LLC read/write requests onto a word-wide pipelined memory bus.
// Latency: first command one cycle after request accept; read line one cycle after last beat.
// Backpressure: one transaction at a time (req_ready only in IDLE); commands stall on
//               mem_cmd_ready with stable payload; response line held until llc_mem_rsp_ready.
// Ports: clk, rst (async, active-low), bus (slave modport of llc_mem_bridge_if).
module llc_mem_bridge #(
   parameter int WORDS_PER_LINE = llc_mem_bridge_pkg::WORDS_PER_LINE,
   parameter int BITS_PER_WORD  = llc_mem_bridge_pkg::BITS_PER_WORD,
   parameter int ADDR_BITS      = llc_mem_bridge_pkg::ADDR_BITS
) (
   input  logic             clk,
   input  logic             rst,
   llc_mem_bridge_if.slave  bus
);
   import llc_mem_bridge_pkg::*;

   localparam int WO = $clog2(WORDS_PER_LINE);
   localparam int BO = $clog2(BITS_PER_WORD / 8);
   localparam int LA = ADDR_BITS - WO - BO;
   localparam int LB = WORDS_PER_LINE * BITS_PER_WORD;
   localparam int CW = WO + 1;
   localparam logic [CW-1:0] LAST   = CW'(WORDS_PER_LINE - 1);
   localparam logic [CW-1:0] NWORDS = CW'(WORDS_PER_LINE);

   typedef enum logic [1:0] {IDLE, READ, RESP, WRITE} state_e;

   state_e                 state_q, state_d;
   logic [CW-1:0]          cmd_cnt_q, cmd_cnt_d;
   logic                   cmd_vld_q, cmd_vld_d;
   logic                   write_q, write_d;
   logic [LA-1:0]          addr_q, addr_d;
   logic [HPROT_WIDTH-1:0] hprot_q, hprot_d;
   logic [LB-1:0]          wline_q, wline_d;

   logic          cmd_fire;
   logic [CW-1:0] cmd_cnt_post;
   logic          beat_ok;
   logic          asm_clr;
   logic [CW-1:0] beat_cnt;
   logic [LB-1:0] rline;
   logic          asm_full;
   logic [WO-1:0] cmd_idx;
   logic [HSIZE_WIDTH-1:0] unused_hsize;

   // Transfers are always full lines, so the size field carries no information.
   assign unused_hsize = bus.llc_mem_req.hsize;

   assign cmd_fire     = cmd_vld_q & bus.mem_cmd_ready;
   assign cmd_cnt_post = cmd_cnt_q + CW'(cmd_fire);
   // Compare against the post-increment count so a zero-latency memory may
   // return a beat in the same cycle its command is accepted.
   assign beat_ok      = bus.mem_rdata_valid && (state_q == READ) && (beat_cnt < cmd_cnt_post);

   always_comb begin
      state_d   = state_q;
      cmd_cnt_d = cmd_cnt_q;
      write_d   = write_q;
      addr_d    = addr_q;
      hprot_d   = hprot_q;
      wline_d   = wline_q;
      asm_clr   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.llc_mem_req_valid) begin
               write_d   = bus.llc_mem_req.hwrite;
               addr_d    = bus.llc_mem_req.addr;
               hprot_d   = bus.llc_mem_req.hprot;
               wline_d   = bus.llc_mem_req.line;
               cmd_cnt_d = '0;
               asm_clr   = 1'b1;
               state_d   = bus.llc_mem_req.hwrite ? WRITE : READ;
            end
         end
         WRITE: begin
            cmd_cnt_d = cmd_cnt_post;
            if (cmd_fire && (cmd_cnt_q == LAST)) state_d = IDLE;
         end
         READ: begin
            cmd_cnt_d = cmd_cnt_post;
            if (beat_ok && (beat_cnt == LAST)) state_d = RESP;
         end
         RESP: begin
            if (bus.llc_mem_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Registered valid: decided from next state/count so it never depends
      // combinationally on mem_cmd_ready.
      cmd_vld_d = ((state_d == READ) || (state_d == WRITE)) && (cmd_cnt_d < NWORDS);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cmd_cnt_q <= '0;
         cmd_vld_q <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         hprot_q   <= '0;
         wline_q   <= '0;
      end else begin
         state_q   <= state_d;
         cmd_cnt_q <= cmd_cnt_d;
         cmd_vld_q <= cmd_vld_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         hprot_q   <= hprot_d;
         wline_q   <= wline_d;
      end
   end

   llc_line_assembler #(
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .BITS_PER_WORD  (BITS_PER_WORD)
   ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (asm_clr),
      .beat_vld_i (beat_ok),
      .beat_dat_i (bus.mem_rdata),
      .line_o     (rline),
      .beat_cnt_o (beat_cnt),
      .full_o     (asm_full)
   );

   // Payload is a pure mux of registered state, so it holds while stalled.
   assign cmd_idx           = cmd_cnt_q[WO-1:0];
   assign bus.mem_cmd_valid = cmd_vld_q;
   assign bus.mem_cmd_write = write_q;
   assign bus.mem_cmd_addr  = {addr_q, cmd_idx, {BO{1'b0}}};
   assign bus.mem_cmd_hprot = hprot_q;
   assign bus.mem_cmd_wdata = wline_q[cmd_idx*BITS_PER_WORD +: BITS_PER_WORD];

   assign bus.llc_mem_req_ready = (state_q == IDLE);
   assign bus.llc_mem_rsp_valid = (state_q == RESP);
   assign bus.llc_mem_rsp       = '{line: rline};

   a_no_stray_beat: assert property (@(posedge clk) disable iff (!rst)
      bus.mem_rdata_valid |-> beat_ok)
      else $warning("llc_mem_bridge: read beat discarded (no outstanding read)");

   a_resp_full: assert property (@(posedge clk) disable iff (!rst)
      (state_q == RESP) |-> asm_full);

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Scoreboard bench for llc_mem_bridge with a latency-configurable memory responder.
module tb_llc_mem_bridge;
   import llc_mem_bridge_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   llc_mem_bridge_if bus();

   llc_mem_bridge dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   typedef struct {
      int          tag;
      logic        wr;
      logic [31:0] addr;
      logic [1:0]  hprot;
      logic [31:0] wdata;
   } cmd_exp_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   cmd_exp_t    exp_cmd[$];
   line_t       exp_rsp[$];
   pend_t       pend[$];
   logic [31:0] mem [logic [31:0]];

   int next_tag      = 1;
   int acc_txn       = 0;
   int mem_lat       = 3;
   bit ready_toggle  = 0;
   int rsp_stall     = 0;
   int rsp_stall_cnt = 0;
   bit spur_req      = 0;
   int cmds_fired    = 0;
   int last_beat_cyc = -100;
   bit rsp_vld_prev  = 0;
   bit stall_prev    = 0;
   bit rstall_prev   = 0;
   logic [66:0] held_cmd;
   line_t       held_line;

   // Memory + LLC response-side driver: acts just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         bus.mem_cmd_ready   = ready_toggle ? (cyc % 3 == 0) : 1'b1;
         bus.mem_rdata_valid = 1'b0;
         bus.mem_rdata       = '0;
         if (spur_req) begin
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = 32'hDEAD_BEEF;
            spur_req            = 0;
         end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            pend_t p;
            p = pend.pop_front();
            bus.mem_rdata_valid = 1'b1;
            bus.mem_rdata       = mem.exists(p.addr) ? mem[p.addr] : 32'h0;
         end
         if (bus.llc_mem_rsp_valid) begin
            bus.llc_mem_rsp_ready = (rsp_stall_cnt >= rsp_stall);
            rsp_stall_cnt++;
         end else begin
            rsp_stall_cnt         = 0;
            bus.llc_mem_rsp_ready = (rsp_stall == 0);
         end
      end
   end

   // Monitor: samples on the falling edge, pops and compares.
   always @(negedge clk) begin
      if (rst) begin
         if (stall_prev)
            chk("cmd_stall_stable",
                {bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_cmd_hprot, bus.mem_cmd_wdata}, held_cmd);
         stall_prev = bus.mem_cmd_valid && !bus.mem_cmd_ready;
         held_cmd   = {bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_cmd_hprot, bus.mem_cmd_wdata};

         if (bus.mem_cmd_valid && bus.mem_cmd_ready) begin
            if (exp_cmd.size() == 0) begin
               chk("cmd_unexpected", {bus.mem_cmd_write, bus.mem_cmd_addr}, '1);
            end else begin
               cmd_exp_t e;
               e = exp_cmd.pop_front();
               chk("cmd_txn", e.tag, acc_txn);
               chk("cmd_write", bus.mem_cmd_write, e.wr);
               chk("cmd_addr", bus.mem_cmd_addr, e.addr);
               chk("cmd_hprot", bus.mem_cmd_hprot, e.hprot);
               if (e.wr) chk("cmd_wdata", bus.mem_cmd_wdata, e.wdata);
            end
            cmds_fired++;
            if (bus.mem_cmd_write) mem[bus.mem_cmd_addr] = bus.mem_cmd_wdata;
            else pend.push_back('{addr: bus.mem_cmd_addr, due: cyc + mem_lat});
         end

         if (bus.mem_rdata_valid && exp_rsp.size() > 0) last_beat_cyc = cyc;

         if (bus.llc_mem_rsp_valid && !rsp_vld_prev) begin
            if (exp_rsp.size() == 0) chk("rsp_unexpected", bus.llc_mem_rsp.line, '0 - 1);
            else chk("rsp_latency", cyc, last_beat_cyc + 1);
         end
         if (rstall_prev) chk("rsp_hold", bus.llc_mem_rsp.line, held_line);
         rstall_prev  = bus.llc_mem_rsp_valid && !bus.llc_mem_rsp_ready;
         held_line    = bus.llc_mem_rsp.line;
         rsp_vld_prev = bus.llc_mem_rsp_valid;
         if (bus.llc_mem_rsp_valid && bus.llc_mem_rsp_ready && exp_rsp.size() > 0)
            chk("rsp_line", bus.llc_mem_rsp.line, exp_rsp.pop_front());

         if (bus.llc_mem_req_valid && bus.llc_mem_req_ready) begin
            chk("req_order", (exp_cmd.size() > 0) ? exp_cmd[0].tag : -1, acc_txn + 1);
            acc_txn++;
         end
      end
   end

   task automatic push_cmds(input bit wr, input logic [31:0] base, input logic [1:0] hp, input line_t ln);
      for (int i = 0; i < 4; i++)
         exp_cmd.push_back('{tag: next_tag, wr: wr, addr: base + 32'(4 * i), hprot: hp,
                             wdata: ln[i*32 +: 32]});
      next_tag++;
   endtask

   task automatic send_req(input bit wr, input logic [27:0] a, input logic [1:0] hp,
                           input line_t ln, input bit hold);
      bit ok;
      ok = 0;
      @(posedge clk);
      #1;
      bus.llc_mem_req_valid = 1'b1;
      bus.llc_mem_req = '{hwrite: wr, hsize: 3'd4, hprot: hp, addr: a, line: ln};
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (bus.llc_mem_req_ready) ok = 1;
      end
      if (!ok) chk("req_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (!hold) bus.llc_mem_req_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (exp_cmd.size() == 0 && exp_rsp.size() == 0 && bus.llc_mem_req_ready) ok = 1;
      end
      if (!ok) chk("done_timeout", exp_cmd.size() + exp_rsp.size(), 0);
   endtask

   task automatic chk_reset_vals(input string tagname);
      chk({tagname, "_req_ready"}, bus.llc_mem_req_ready, 1'b1);
      chk({tagname, "_rsp_valid"}, bus.llc_mem_rsp_valid, 1'b0);
      chk({tagname, "_cmd_valid"}, bus.mem_cmd_valid, 1'b0);
      chk({tagname, "_cmd_payload"},
          {bus.mem_cmd_write, bus.mem_cmd_addr, bus.mem_cmd_hprot, bus.mem_cmd_wdata}, '0);
      chk({tagname, "_rsp_line"}, bus.llc_mem_rsp.line, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      bus.llc_mem_req_valid = 1'b0;
      bus.llc_mem_req       = '0;
      bus.llc_mem_rsp_ready = 1'b1;
      bus.mem_cmd_ready     = 1'b1;
      bus.mem_rdata_valid   = 1'b0;
      bus.mem_rdata         = '0;

      for (int i = 0; i < 4; i++) begin
         mem[32'h100 + 32'(4*i)]  = 32'h11 * (i + 1);
         mem[32'hABC0 + 32'(4*i)] = 32'hA0 + 32'(i);
         mem[32'h200 + 32'(4*i)]  = 32'h5000_0000 + 32'(i);
         mem[32'h300 + 32'(4*i)]  = 32'h7700_0000 + 32'(i);
      end

      #12;
      chk_reset_vals("reset");
      @(negedge clk);
      rst = 1'b1;

      // 1: line write, memory always ready
      push_cmds(1, 32'h12340, 2'b01, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
      send_req(1, 28'h1234, 2'b01, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 0);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1) chk("first_cmd_cyc", bus.mem_cmd_valid, 1'b1);
         chk("wr_req_ready_cyc", bus.llc_mem_req_ready, (k == 5));
      end
      wait_done();

      // 2: read, 3-cycle memory latency
      exp_rsp.push_back(128'h00000044_00000033_00000022_00000011);
      push_cmds(0, 32'h100, 2'b10, '0);
      send_req(0, 28'h0010, 2'b10, 128'h5A5A, 0);
      wait_done();

      // 3: read with command stalls and a held response
      ready_toggle = 1;
      rsp_stall    = 5;
      exp_rsp.push_back(128'h000000A3_000000A2_000000A1_000000A0);
      push_cmds(0, 32'hABC0, 2'b11, '0);
      send_req(0, 28'h0ABC, 2'b11, '0, 0);
      wait_done();
      ready_toggle = 0;
      rsp_stall    = 0;

      // 4: back-to-back write then read of the same line, valid held high
      push_cmds(1, 32'h400, 2'b01, 128'h44444444_33333333_22222222_11111111);
      push_cmds(0, 32'h400, 2'b01, '0);
      exp_rsp.push_back(128'h44444444_33333333_22222222_11111111);
      send_req(1, 28'h0040, 2'b01, 128'h44444444_33333333_22222222_11111111, 1);
      send_req(0, 28'h0040, 2'b01, '0, 0);
      wait_done();

      // 5: reset in the middle of a read after two commands
      push_cmds(0, 32'h200, 2'b10, '0);
      begin
         int target;
         target = cmds_fired + 2;
         send_req(0, 28'h0020, 2'b10, '0, 0);
         got = 0;
         for (int i = 0; i < 50 && !got; i++) begin
            if (cmds_fired >= target) got = 1;
            else @(posedge clk);
         end
         if (!got) chk("abort_wait_timeout", cmds_fired, target);
      end
      #3;
      rst = 1'b0;
      #1;
      chk_reset_vals("abort");
      exp_cmd.delete();
      pend.delete();
      stall_prev  = 0;
      rstall_prev = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      exp_rsp.push_back(128'h50000003_50000002_50000001_50000000);
      push_cmds(0, 32'h200, 2'b10, '0);
      send_req(0, 28'h0020, 2'b10, '0, 0);
      wait_done();

      // 6: stray read beat while idle, then a normal read
      spur_req = 1;
      repeat (3) @(posedge clk);
      exp_rsp.push_back(128'h77000003_77000002_77000001_77000000);
      push_cmds(0, 32'h300, 2'b00, '0);
      send_req(0, 28'h0030, 2'b00, '0, 0);
      wait_done();

      repeat (5) @(negedge clk);
      chk("leftover_expectations", exp_cmd.size() + exp_rsp.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
